dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache that sits between the pipelined core's memory stage and the backing data memory.
- The memory stage presents word-aligned load/store requests with byte enables. The cache returns load data and a stall to the hazard logic.
- Misses are serviced by a word-serial refill FSM over a valid/ready backing-memory port.
- Byte/half extraction and sign extension remain in the memory stage.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache_wt.sv | 210 +++++++++++++++++++++
 tb/tb_dcache_wt.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache.
// Holds the controller state enum, the default geometry with the field widths
// derived from it, and the helper that forms a backing address for one word
// of the line that a request addresses.
package dcache_pkg;
   localparam int SETS_DEF   = 16;
   localparam int WORDS_DEF  = 4;
   localparam int ADDR_W_DEF = 32;

   localparam int OFF_W = $clog2(WORDS_DEF);
   localparam int IDX_W = $clog2(SETS_DEF);
   localparam int TAG_W = ADDR_W_DEF - IDX_W - OFF_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      REFILL_REQ,
      REFILL_WAIT,
      WRITE_REQ,
      WRITE_ACK
   } stateT;

   // Keeps the tag and index of addr and replaces the word offset with off.
   function automatic logic [ADDR_W_DEF-1:0] lineWordAddr(input logic [ADDR_W_DEF-1:0] addr,
                                                          input logic [OFF_W-1:0] off);
      return {addr[ADDR_W_DEF-1:OFF_W+2], off, 2'b00};
   endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the direct-mapped cache.
// Ports:
//   clk                      clock
//   clearAll                 synchronous clear of every valid bit
//   rdIdx, rdOff             combinational read address
//   rdValid, rdTag, rdWord   combinational read data
//   wrEn, wrIdx, wrOff       word write port
//   wrData, wrBe             write data and byte enables
//   setValid, setTag         mark line wrIdx valid with setTag
module dcache_array
   import dcache_pkg::*;
#(
   parameter int SETS     = SETS_DEF,
   parameter int WORDS    = WORDS_DEF,
   parameter int TAG_BITS = TAG_W
) (
   input  logic                     clk,
   input  logic                     clearAll,
   input  logic [$clog2(SETS)-1:0]  rdIdx,
   input  logic [$clog2(WORDS)-1:0] rdOff,
   output logic                     rdValid,
   output logic [TAG_BITS-1:0]      rdTag,
   output logic [31:0]              rdWord,
   input  logic                     wrEn,
   input  logic [$clog2(SETS)-1:0]  wrIdx,
   input  logic [$clog2(WORDS)-1:0] wrOff,
   input  logic [31:0]              wrData,
   input  logic [3:0]               wrBe,
   input  logic                     setValid,
   input  logic [TAG_BITS-1:0]      setTag
);
   logic [31:0]         dataMem [SETS*WORDS];
   logic [TAG_BITS-1:0] tagMem  [SETS];
   logic [SETS-1:0]     validBits;

   assign rdValid = validBits[rdIdx];
   assign rdTag   = tagMem[rdIdx];
   assign rdWord  = dataMem[{rdIdx, rdOff}];

   always_ff @(posedge clk) begin
      if (clearAll) begin
         validBits <= '0;
      end else if (setValid) begin
         validBits[wrIdx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (setValid) begin
         tagMem[wrIdx] <= setTag;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wrEn && wrBe[b]) begin
            dataMem[{wrIdx, wrOff}][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// memory stage and the backing data memory. Load hits return data with no
// added latency; misses refill the line one word at a time; every store is
// written through and merged into the line only on a hit.
// Optional build macro DCACHE_STATS_EN adds hit_count / miss_count.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/we/addr/wdata/be   memory-stage request
//   rdata, stall                 load data, pipeline freeze
//   mem_req_valid/ready/we/addr/wdata/be   backing request handshake
//   mem_rsp_valid, mem_rsp_data  backing read return
//   hit_count, miss_count        access statistics (DCACHE_STATS_EN only)
//
// state       | meaning
// IDLE        | serve load hits, dispatch misses and stores
// REFILL_REQ  | issue read for word refillCnt of the missing line
// REFILL_WAIT | wait for that word, write it, advance
// WRITE_REQ   | issue the write-through, merge on hit when accepted
// WRITE_ACK   | release the pipeline past the store for one cycle
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int SETS   = SETS_DEF,
   parameter int WORDS  = WORDS_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_be,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int OFF_B = $clog2(WORDS);
   localparam int IDX_B = $clog2(SETS);
   localparam int TAG_B = ADDR_W - IDX_B - OFF_B - 2;
   localparam logic [OFF_B-1:0] LAST_WORD = OFF_B'(WORDS - 1);

   stateT            state, nextState;
   logic [OFF_B-1:0] refillCnt;

   logic [OFF_B-1:0] reqOff;
   logic [IDX_B-1:0] reqIdx;
   logic [TAG_B-1:0] reqTag;
   logic             unusedAddrLsb;

   logic             rdValid;
   logic [TAG_B-1:0] rdTag;
   logic [31:0]      rdWord;
   logic             hit;

   logic             wrEn;
   logic [OFF_B-1:0] wrOff;
   logic [31:0]      wrData;
   logic [3:0]       wrBe;
   logic             setValid;

   assign reqOff        = req_addr[OFF_B+1:2];
   assign reqIdx        = req_addr[IDX_B+OFF_B+1:OFF_B+2];
   assign reqTag        = req_addr[ADDR_W-1:ADDR_W-TAG_B];
   assign unusedAddrLsb = ^req_addr[1:0];
   assign hit           = rdValid && (rdTag == reqTag);

   dcache_array #(
      .SETS     (SETS),
      .WORDS    (WORDS),
      .TAG_BITS (TAG_B)
   ) uArray (
      .clk      (clk),
      .clearAll (rst),
      .rdIdx    (reqIdx),
      .rdOff    (reqOff),
      .rdValid  (rdValid),
      .rdTag    (rdTag),
      .rdWord   (rdWord),
      .wrEn     (wrEn),
      .wrIdx    (reqIdx),
      .wrOff    (wrOff),
      .wrData   (wrData),
      .wrBe     (wrBe),
      .setValid (setValid),
      .setTag   (reqTag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         refillCnt <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE) begin
            refillCnt <= '0;
         end else if (state == REFILL_WAIT && mem_rsp_valid) begin
            refillCnt <= refillCnt + 1'b1;
         end
      end
   end

   always_comb begin
      nextState     = state;
      stall         = 1'b0;
      rdata         = '0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = lineWordAddr(req_addr, refillCnt);
      mem_req_wdata = req_wdata;
      mem_req_be    = 4'hF;
      wrEn          = 1'b0;
      wrOff         = refillCnt;
      wrData        = mem_rsp_data;
      wrBe          = 4'hF;
      setValid      = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_we) begin
                  stall     = 1'b1;
                  nextState = WRITE_REQ;
               end else if (hit) begin
                  rdata = rdWord;
               end else begin
                  stall     = 1'b1;
                  nextState = REFILL_REQ;
               end
            end
         end
         REFILL_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               nextState = REFILL_WAIT;
            end
         end
         REFILL_WAIT: begin
            stall = 1'b1;
            if (mem_rsp_valid) begin
               wrEn = 1'b1;
               if (refillCnt == LAST_WORD) begin
                  // Line complete: the access is re-evaluated in IDLE and hits.
                  setValid  = 1'b1;
                  nextState = IDLE;
               end else begin
                  nextState = REFILL_REQ;
               end
            end
         end
         WRITE_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_req_be    = req_be;
            if (mem_req_ready) begin
               if (hit) begin
                  wrEn   = 1'b1;
                  wrOff  = reqOff;
                  wrData = req_wdata;
                  wrBe   = req_be;
               end
               nextState = WRITE_ACK;
            end
         end
         WRITE_ACK: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

`ifdef DCACHE_STATS_EN
   // reEval marks the IDLE cycle that re-checks an access after its refill,
   // which was already counted as a miss.
   logic reEval;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         reEval     <= 1'b0;
      end else begin
         reEval <= (state == REFILL_WAIT) && (nextState == IDLE);
         if (state == IDLE && req_valid && !reEval) begin
            if (hit) begin
               hit_count <= hit_count + 32'd1;
            end else begin
               miss_count <= miss_count + 32'd1;
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt. The reference model is the backing memory itself
// (a write-through cache must always return what memory holds) plus a
// per-set record of which line is resident, from which stalls and backing
// traffic are predicted.
module tb_dcache_wt;
   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   dcache_wt dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_be        (req_be),
      .rdata         (rdata),
      .stall         (stall),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_be    (mem_req_be),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem [0:1023];
   logic        mValid [16];
   logic [23:0] mTag [16];
   int          readyDelay = 0;
   int          rspLat = 2;
   logic [31:0] refillQ [$];
   logic [31:0] writeQ [$];
   int          memValidCycles = 0;
   int          statHit = 0;
   int          statMiss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Backing memory: ready after readyDelay cycles of valid, read data
   // rspLat cycles after acceptance.
   initial begin
      logic        accNow, aWe, pending;
      logic [31:0] aAddr, aWd, pAddr;
      logic [3:0]  aBe;
      int          waitCnt, rspCnt;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      pending = 1'b0;
      waitCnt = 0;
      rspCnt  = 0;
      pAddr   = '0;
      forever begin
         @(negedge clk);
         accNow = mem_req_valid && mem_req_ready && !rst;
         aWe    = mem_req_we;
         aAddr  = mem_req_addr;
         aWd    = mem_req_wdata;
         aBe    = mem_req_be;
         @(posedge clk);
         #2;
         mem_rsp_valid = 1'b0;
         if (rst) begin
            pending       = 1'b0;
            mem_req_ready = 1'b0;
            waitCnt       = 0;
         end else begin
            if (accNow) begin
               mem_req_ready = 1'b0;
               waitCnt       = 0;
               if (aWe) begin
                  for (int b = 0; b < 4; b++)
                     if (aBe[b]) mem[aAddr[11:2]][8*b +: 8] = aWd[8*b +: 8];
                  writeQ.push_back(aAddr);
               end else begin
                  pending = 1'b1;
                  pAddr   = aAddr;
                  rspCnt  = rspLat;
                  refillQ.push_back(aAddr);
               end
            end
            if (pending) begin
               rspCnt--;
               if (rspCnt == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_data  = mem[pAddr[11:2]];
                  pending       = 1'b0;
               end
            end
            if (mem_req_valid && !mem_req_ready) begin
               if (waitCnt >= readyDelay) mem_req_ready = 1'b1;
               else waitCnt++;
            end else if (!mem_req_valid) begin
               mem_req_ready = 1'b0;
               waitCnt       = 0;
            end
         end
      end
   end

   // Per-cycle compare against the memory model and handshake rules.
   initial begin
      logic        prevPend;
      logic [31:0] pAddr, pWd;
      logic [3:0]  pBe;
      logic        pWe;
      prevPend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevPend = 1'b0;
         end else begin
            if (mem_req_valid) memValidCycles++;
            if (prevPend) begin
               chk("reqHold", 32'(mem_req_valid), 32'd1);
               chk("reqAddrStable", mem_req_addr, pAddr);
               chk("reqWeStable", 32'(mem_req_we), 32'(pWe));
               chk("reqBeStable", 32'(mem_req_be), 32'(pBe));
               if (pWe) chk("reqWdataStable", mem_req_wdata, pWd);
            end
            if (!req_valid) begin
               chk("idleStall", 32'(stall), 32'd0);
               chk("idleRdata", rdata, 32'd0);
            end else if (!req_we && !stall) begin
               chk("loadData", rdata, mem[req_addr[11:2]]);
            end
            if (mem_req_valid && mem_req_we) begin
               chk("wrAddr", mem_req_addr, {req_addr[31:2], 2'b00});
               chk("wrData", mem_req_wdata, req_wdata);
               chk("wrBe", 32'(mem_req_be), 32'(req_be));
            end
            if (mem_req_valid && !mem_req_we) begin
               chk("rdLine", 32'(mem_req_addr[31:4]), 32'(req_addr[31:4]));
               chk("rdBe", 32'(mem_req_be), 32'hF);
            end
            prevPend = mem_req_valid && !mem_req_ready;
            pAddr    = mem_req_addr;
            pWd      = mem_req_wdata;
            pBe      = mem_req_be;
            pWe      = mem_req_we;
         end
      end
   end

   // One access, started just after a rising edge; returns stall cycles and
   // the load data seen in the cycle the stall released.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int stallCyc, output logic [31:0] rd);
      logic [3:0]  idx;
      logic [23:0] tag;
      logic [31:0] lineBase;
      logic        expHit, done;
      int          expStall, expValid;
      idx      = addr[7:4];
      tag      = addr[31:8];
      lineBase = {addr[31:4], 4'b0000};
      expHit   = mValid[idx] && (mTag[idx] == tag);
      if (we) begin
         expStall = 2 + readyDelay;
         expValid = readyDelay + 1;
      end else if (expHit) begin
         expStall = 0;
         expValid = 0;
      end else begin
         expStall = 1 + 4 * (readyDelay + 1 + rspLat);
         expValid = 4 * (readyDelay + 1);
      end
      refillQ.delete();
      writeQ.delete();
      memValidCycles = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      stallCyc  = 0;
      rd        = '0;
      done      = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (stall) begin
            stallCyc++;
            @(posedge clk);
            #1;
         end else begin
            done = 1'b1;
            rd   = rdata;
         end
      end
      chk("accessDone", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("stallCycles", 32'(stallCyc), 32'(expStall));
      chk("memValidCycles", 32'(memValidCycles), 32'(expValid));
      if (!we) begin
         chk("loadResult", rd, mem[addr[11:2]]);
         chk("writeCount", 32'(writeQ.size()), 32'd0);
         if (expHit) begin
            chk("refillCount", 32'(refillQ.size()), 32'd0);
         end else begin
            chk("refillCount", 32'(refillQ.size()), 32'd4);
            for (int k = 0; k < refillQ.size() && k < 4; k++)
               chk("refillAddr", refillQ[k], lineBase + 32'(4 * k));
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
         end
      end else begin
         chk("refillCount", 32'(refillQ.size()), 32'd0);
         chk("writeCount", 32'(writeQ.size()), 32'd1);
         if (writeQ.size() == 1) chk("writeAddr", writeQ[0], {addr[31:2], 2'b00});
      end
      if (expHit) statHit++;
      else statMiss++;
   endtask

   task automatic clearModel();
      for (int s = 0; s < 16; s++) begin
         mValid[s] = 1'b0;
         mTag[s]   = '0;
      end
      statHit  = 0;
      statMiss = 0;
   endtask

   initial begin
      int          sc;
      logic [31:0] rd, a;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[16] = 32'h11;
      mem[17] = 32'h22;
      mem[18] = 32'h33;
      mem[19] = 32'h44;
      mem[80] = 32'h5555_0140;
      clearModel();

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("resetStall", 32'(stall), 32'd0);
      chk("resetRdata", rdata, 32'd0);
      chk("resetMemValid", 32'(mem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // cold load, ready immediately, 2-cycle response
      readyDelay = 0;
      rspLat     = 2;
      access(1'b0, 32'h40, '0, '0, sc, rd);
      chk("t1Stall", 32'(sc), 32'd13);
      chk("t1Data", rd, 32'h11);
      if (refillQ.size() == 4) begin
         chk("t1Addr0", refillQ[0], 32'h40);
         chk("t1Addr1", refillQ[1], 32'h44);
         chk("t1Addr2", refillQ[2], 32'h48);
         chk("t1Addr3", refillQ[3], 32'h4C);
      end else begin
         chk("t1Refills", 32'(refillQ.size()), 32'd4);
      end

      access(1'b0, 32'h48, '0, '0, sc, rd);
      chk("t2Stall", 32'(sc), 32'd0);
      chk("t2Data", rd, 32'h33);
      chk("t2NoMem", 32'(memValidCycles), 32'd0);

      readyDelay = 3;
      access(1'b1, 32'h44, 32'hAABBCCDD, 4'b0011, sc, rd);
      chk("t3StoreStall", 32'(sc), 32'd5);
      chk("t3ValidHeld", 32'(memValidCycles), 32'd4);
      readyDelay = 0;
      access(1'b0, 32'h44, '0, '0, sc, rd);
      chk("t3Stall", 32'(sc), 32'd0);
      chk("t3Merged", rd, 32'h0000CCDD);

      access(1'b1, 32'h100, 32'h1234_5678, 4'hF, sc, rd);
      chk("t4StoreStall", 32'(sc), 32'd2);
      access(1'b0, 32'h100, '0, '0, sc, rd);
      chk("t4NoAllocate", 32'(sc), 32'd13);
      chk("t4Data", rd, 32'h1234_5678);

      // zero byte enables: write issued, line unchanged
      access(1'b1, 32'h48, 32'hFFFF_FFFF, 4'b0000, sc, rd);
      access(1'b0, 32'h48, '0, '0, sc, rd);
      chk("beZeroData", rd, 32'h33);

      access(1'b0, 32'h140, '0, '0, sc, rd);
      chk("t5Miss0", 32'(sc), 32'd13);
      chk("t5Data0", rd, 32'h5555_0140);
      access(1'b0, 32'h40, '0, '0, sc, rd);
      chk("t5Miss1", 32'(sc), 32'd13);
      chk("t5Data1", rd, 32'h11);
      access(1'b0, 32'h140, '0, '0, sc, rd);
      chk("t5Miss2", 32'(sc), 32'd13);

      // reset during the second REFILL_WAIT cycle
      rspLat    = 3;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h180;
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6MemValid", 32'(mem_req_valid), 32'd0);
      chk("t6Stall", 32'(stall), 32'd0);
      clearModel();
      @(posedge clk);
      #1;
      rspLat = 2;
      access(1'b0, 32'h40, '0, '0, sc, rd);
      chk("t6Miss", 32'(sc), 32'd13);
      chk("t6Data", rd, 32'h11);

      for (int n = 0; n < 400; n++) begin
         readyDelay = $urandom_range(0, 2);
         rspLat     = $urandom_range(1, 3);
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 3)
            access(1'b1, a, $urandom, 4'($urandom_range(0, 15)), sc, rd);
         else
            access(1'b0, a, '0, '0, sc, rd);
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end

`ifdef DCACHE_STATS_EN
      @(negedge clk);
      chk("hitCount", hit_count, 32'(statHit));
      chk("missCount", miss_count, 32'(statMiss));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
